stream_demux: RTL and testbench

- Routes a single valid/ready input stream to one of N_OUT output streams, chosen by a per-beat select.
- Each output has a one-entry register slice, so one busy output does not block beats headed elsewhere except on the cycle it is targeted.
- Counterpart of the mux primitives: one source fans out to many sinks, where a mux selects many sources into one.
- Beats with an out-of-range select are dropped and counted.

---
 rtl/stream_demux_if.sv | 25 ++
 rtl/stream_demux.sv | 93 +++++++++
 tb/tb_stream_demux.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Valid/ready bundle for stream_demux: one upstream port and N_OUT downstream channels.
// master drives the upstream beat and the sink readies; slave is the demux itself.
interface stream_demux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
  logic                     up_valid;
  logic                     up_ready;
  logic [WIDTH-1:0]         up_data;
  logic [SEL_W-1:0]         up_sel;
  logic [N_OUT-1:0]         down_valid;
  logic [N_OUT-1:0]         down_ready;
  logic [N_OUT*WIDTH-1:0]   down_data;

  modport master (
    output up_valid, up_data, up_sel, down_ready,
    input  up_ready, down_valid, down_data
  );

  modport slave (
    input  up_valid, up_data, up_sel, down_ready,
    output up_ready, down_valid, down_data
  );
endinterface

// File: rtl/stream_demux.sv
// One-to-N stream demux with a one-entry register slice per output channel.
// Define STREAM_DEMUX_RR_EN to ignore up_sel and rotate destinations round-robin.
module stream_demux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N_OUT-1:0]       full_q, full_d;
  logic [N_OUT*WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       dest;
  logic                   in_range;
  logic                   sel_full;
  logic                   sel_ready;
  logic                   accept;

`ifdef STREAM_DEMUX_RR_EN
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);
  logic [SEL_W-1:0] rr_q, rr_d;
  assign dest = rr_q;
`else
  assign dest = bus.up_sel;
`endif

  assign in_range = (32'(dest) < N_OUT);

  // Occupancy and sink readiness of the targeted channel
  always_comb begin
    sel_full  = 1'b0;
    sel_ready = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (dest == SEL_W'(k)) begin
        sel_full  = full_q[k];
        sel_ready = bus.down_ready[k];
      end
    end
  end

  // Drop path never back-pressures; a channel takes a beat when empty or draining
  assign bus.up_ready = ~in_range | ~sel_full | sel_ready;
  assign accept       = bus.up_valid & bus.up_ready;

  always_comb begin
    full_d = full_q & ~bus.down_ready;
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (accept && in_range && (dest == SEL_W'(k))) begin
        full_d[k]                 = 1'b1;
        data_d[k*WIDTH +: WIDTH]  = bus.up_data;
      end
    end
    if (accept && !in_range && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`ifdef STREAM_DEMUX_RR_EN
    rr_d = rr_q;
    if (accept) begin
      rr_d = (rr_q == LAST) ? '0 : rr_q + SEL_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
`ifdef STREAM_DEMUX_RR_EN
      rr_q   <= '0;
`endif
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
`ifdef STREAM_DEMUX_RR_EN
      rr_q   <= rr_d;
`endif
    end
  end

  assign bus.down_valid = full_q;
  assign bus.down_data  = data_q;
  assign drop_cnt       = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Randomized + directed bench for stream_demux against a per-channel queue model.
// Honours STREAM_DEMUX_RR_EN the same way the design does.
module tb_stream_demux;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_OUT = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  stream_demux_if #(.WIDTH(WIDTH), .N_OUT(N_OUT), .SEL_W(SEL_W)) bus ();

  stream_demux #(.WIDTH(WIDTH), .N_OUT(N_OUT), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a queue of beats accepted but not yet taken by the sink
  logic [WIDTH-1:0] q [N_OUT][$];
  logic [WIDTH-1:0] last [N_OUT];
  int               m_drop;
  int               m_rr;

  function automatic int model_dest();
`ifdef STREAM_DEMUX_RR_EN
    return m_rr;
`else
    return int'(bus.up_sel);
`endif
  endfunction

  function automatic logic model_ready();
    int d;
    d = model_dest();
    if (d >= int'(N_OUT)) return 1'b1;
    return (q[d].size() == 0) || bus.down_ready[d];
  endfunction

  // Compare on the falling edge, then advance the model by the coming rising edge
  always @(negedge clk) begin
    logic exp_rdy;
    int   d;
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) begin
        q[k].delete();
        last[k] = '0;
      end
      m_drop = 0;
      m_rr   = 0;
    end
    exp_rdy = model_ready();
    chk("up_ready", 32'(bus.up_ready), 32'(exp_rdy));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    for (int k = 0; k < N_OUT; k++) begin
      chk($sformatf("down_valid[%0d]", k), 32'(bus.down_valid[k]), 32'(q[k].size() != 0));
      chk($sformatf("down_data[%0d]", k), 32'(bus.down_data[k*WIDTH +: WIDTH]),
          32'((q[k].size() != 0) ? q[k][0] : last[k]));
    end
    if (rst_n) begin
      d = model_dest();
      for (int k = 0; k < N_OUT; k++)
        if (q[k].size() != 0 && bus.down_ready[k]) void'(q[k].pop_front());
      if (bus.up_valid && exp_rdy) begin
        if (d < int'(N_OUT)) begin
          q[d].push_back(bus.up_data);
          last[d] = bus.up_data;
        end else if (m_drop < 255) begin
          m_drop++;
        end
        m_rr = (m_rr == int'(N_OUT) - 1) ? 0 : m_rr + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] d);
    bus.up_valid = v;
    bus.up_sel   = s;
    bus.up_data  = d;
  endtask

  initial begin
    logic acc;
    bus.up_valid   = 1'b0;
    bus.up_sel     = '0;
    bus.up_data    = '0;
    bus.down_ready = '0;

    // Reset held with sinks stalled
    repeat (3) step();
    chk("rst_valid", 32'(bus.down_valid), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    rst_n = 1'b1;
    step();

`ifndef STREAM_DEMUX_RR_EN
    // Async reset while channel 1 holds a beat
    drive(1'b1, 2'd1, 8'h5C);
    step();
    drive(1'b0, 2'd0, 8'h00);
    chk("hold_ch1", 32'(bus.down_valid), 32'h2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_rst_ch1", 32'(bus.down_valid), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Single route to channel 2
    bus.down_ready = 3'b111;
    drive(1'b1, 2'd2, 8'hA5);
    step();
    drive(1'b0, 2'd0, 8'h00);
    chk("route_valid", 32'(bus.down_valid), 32'h4);
    chk("route_data", 32'(bus.down_data[23:16]), 32'hA5);
    step();

    // Backpressure on channel 0, independence of channel 1
    bus.down_ready = 3'b110;
    drive(1'b1, 2'd0, 8'h11);
    #1 chk("bp_first_ready", 32'(bus.up_ready), 32'h1);
    step();
    drive(1'b1, 2'd0, 8'h22);
    #1 chk("bp_second_ready", 32'(bus.up_ready), 32'h0);
    step();
    drive(1'b0, 2'd0, 8'h00);
    step();
    drive(1'b1, 2'd1, 8'h33);
    #1 chk("indep_ready", 32'(bus.up_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    chk("indep_valid", 32'(bus.down_valid), 32'h3);
    chk("indep_d0", 32'(bus.down_data[7:0]), 32'h11);
    chk("indep_d1", 32'(bus.down_data[15:8]), 32'h33);
    step();
    drive(1'b1, 2'd0, 8'h22);
    #1 chk("bp_stall", 32'(bus.up_ready), 32'h0);
    step();
    bus.down_ready = 3'b111;
    #1 chk("bp_release", 32'(bus.up_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    chk("reload_valid", 32'(bus.down_valid[0]), 32'h1);
    chk("reload_data", 32'(bus.down_data[7:0]), 32'h22);
    step();
    chk("drained", 32'(bus.down_valid), 32'h0);

    // Drop path saturates the counter
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, 8'(i));
      step();
    end
    drive(1'b0, 2'd0, 8'h00);
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    chk("drop_no_valid", 32'(bus.down_valid), 32'h0);
`else
    // Round-robin distribution
    bus.down_ready = 3'b111;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 2'd0, 8'(i));
      step();
      chk("rr_valid", 32'(bus.down_valid), 32'(1 << ((i - 1) % 3)));
      chk("rr_data", 32'(bus.down_data[((i - 1) % 3)*WIDTH +: WIDTH]), 32'(i));
    end
    drive(1'b0, 2'd0, 8'h00);
    step();
    // Stall channel 1: no skipping to channel 2
    bus.down_ready = 3'b101;
    for (int i = 7; i <= 10; i++) begin
      drive(1'b1, 2'd0, 8'(i));
      step();
    end
    drive(1'b1, 2'd0, 8'd11);
    #1 chk("rr_stall_ready", 32'(bus.up_ready), 32'h0);
    step();
    chk("rr_ch2_empty", 32'(bus.down_valid[2]), 32'h0);
    chk("rr_ch1_held", 32'(bus.down_data[15:8]), 32'd8);
    bus.down_ready = 3'b111;
    step();
    drive(1'b0, 2'd0, 8'h00);
    repeat (2) step();
`endif

    // Random traffic; upstream holds sel/data until its beat is taken
    acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (acc || !bus.up_valid) begin
        bus.up_valid = ($urandom_range(0, 3) != 0);
        bus.up_sel   = SEL_W'($urandom_range(0, 3));
        bus.up_data  = WIDTH'($urandom);
      end
      bus.down_ready = N_OUT'($urandom);
      #2 acc = bus.up_valid & bus.up_ready;
      step();
    end

    drive(1'b0, 2'd0, 8'h00);
    bus.down_ready = '1;
    repeat (3) step();
    chk("final_empty", 32'(bus.down_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
